// File: rtl/bank_fifo_array_pkg.sv
// Shared definitions for the banked FIFO array.
// Holds the default parameter values and the per-channel status record
// that each channel reports to the array top.
package bank_fifo_array_pkg;

  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_FIFO_DEPTH = 4;   // log2 of entries per channel
  localparam int DEF_NUM_CH     = 4;
  localparam int DEF_AF_LEVEL   = 12;

  // Count field is sized for the largest supported depth (FIFO_DEPTH <= 16).
  // The array top keeps only the low FIFO_DEPTH+1 bits.
  localparam int MAX_CNT_W = 17;

  typedef struct packed {
    logic                 full;
    logic                 empty;
    logic                 almost_full;
    logic [MAX_CNT_W-1:0] count;
  } ch_status_t;

endpackage

// File: rtl/bank_fifo_channel.sv
// Single channel of the banked FIFO array.
// First-word-fall-through FIFO with (FIFO_DEPTH+1)-bit pointers (MSB = wrap).
// Status flags are registered from the next-state pointers, so they track the
// pointer registers exactly.
//
// Ports:
//   i_clk, i_rst       clock, synchronous active-high reset
//   i_wr, i_data       write request already decoded for this channel, payload
//   i_rd               read request already decoded for this channel
//   o_head             entry at the read pointer (don't-care when empty)
//   o_status           registered full / empty / almost_full / count
//   o_overflow,        sticky dropped-write / dropped-read flags, present only
//   o_underflow        when BANK_FIFO_ERR_STICKY_EN is defined
module bank_fifo_channel
  import bank_fifo_array_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
  parameter int AF_LEVEL   = DEF_AF_LEVEL
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_wr,
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic                  i_rd,
  output logic [DATA_WIDTH-1:0] o_head,
  output ch_status_t            o_status
`ifdef BANK_FIFO_ERR_STICKY_EN
  ,
  output logic                  o_overflow,
  output logic                  o_underflow
`endif
);

  localparam int PW      = FIFO_DEPTH + 1;
  localparam int ENTRIES = 1 << FIFO_DEPTH;
  localparam logic [PW-1:0] AF_CNT = PW'(AF_LEVEL);

  logic [DATA_WIDTH-1:0] mem [ENTRIES];

  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [PW-1:0] wr_ptr_nxt, rd_ptr_nxt, cnt_nxt, cnt_q;
  logic          full_q, empty_q, af_q;
  logic          wr_acc, rd_acc;

  // Acceptance uses the registered flags, which equal the current pointer
  // state; a full channel therefore takes only a read, an empty one only a write.
  assign wr_acc     = i_wr & ~full_q;
  assign rd_acc     = i_rd & ~empty_q;
  assign wr_ptr_nxt = wr_ptr + PW'(wr_acc);
  assign rd_ptr_nxt = rd_ptr + PW'(rd_acc);
  assign cnt_nxt    = wr_ptr_nxt - rd_ptr_nxt;

  always_ff @(posedge i_clk) begin
    if (wr_acc) begin
      mem[wr_ptr[FIFO_DEPTH-1:0]] <= i_data;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
      af_q    <= 1'b0;
      cnt_q   <= '0;
    end else begin
      wr_ptr  <= wr_ptr_nxt;
      rd_ptr  <= rd_ptr_nxt;
      full_q  <= (wr_ptr_nxt[FIFO_DEPTH-1:0] == rd_ptr_nxt[FIFO_DEPTH-1:0]) &&
                 (wr_ptr_nxt[FIFO_DEPTH] != rd_ptr_nxt[FIFO_DEPTH]);
      empty_q <= (wr_ptr_nxt == rd_ptr_nxt);
      af_q    <= (cnt_nxt >= AF_CNT);
      cnt_q   <= cnt_nxt;
    end
  end

  assign o_head = mem[rd_ptr[FIFO_DEPTH-1:0]];

  always_comb begin
    o_status             = '0;
    o_status.full        = full_q;
    o_status.empty       = empty_q;
    o_status.almost_full = af_q;
    o_status.count       = MAX_CNT_W'(cnt_q);
  end

`ifdef BANK_FIFO_ERR_STICKY_EN
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_overflow  <= 1'b0;
      o_underflow <= 1'b0;
    end else begin
      if (i_wr && full_q) begin
        o_overflow <= 1'b1;
      end
      if (i_rd && empty_q) begin
        o_underflow <= 1'b1;
      end
    end
  end
`endif

endmodule

// File: rtl/bank_fifo_array.sv
// Array of NUM_CH independent FIFO channels sharing one write port and one
// read port. This level only decodes the channel selects, muxes the read head
// and packs the per-channel status into flat output vectors.
//
// Ports:
//   i_clk, i_rst            clock, synchronous active-high reset
//   i_wr_en, i_wr_ch,       write request, channel, payload
//   i_data
//   i_rd_en, i_rd_ch        pop request, channel
//   o_data                  combinational head of channel i_rd_ch
//   o_full, o_empty,        per-channel registered flags
//   o_almost_full
//   o_count                 per-channel occupancy, FIFO_DEPTH+1 bits each
//   o_overflow,             sticky per-channel error flags, only when
//   o_underflow             BANK_FIFO_ERR_STICKY_EN is defined
module bank_fifo_array
  import bank_fifo_array_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
  parameter int NUM_CH     = DEF_NUM_CH,
  parameter int AF_LEVEL   = DEF_AF_LEVEL,
  localparam int CH_W      = $clog2(NUM_CH)
) (
  input  logic                              i_clk,
  input  logic                              i_rst,
  input  logic                              i_wr_en,
  input  logic [CH_W-1:0]                   i_wr_ch,
  input  logic [DATA_WIDTH-1:0]             i_data,
  input  logic                              i_rd_en,
  input  logic [CH_W-1:0]                   i_rd_ch,
  output logic [DATA_WIDTH-1:0]             o_data,
  output logic [NUM_CH-1:0]                 o_full,
  output logic [NUM_CH-1:0]                 o_empty,
  output logic [NUM_CH-1:0]                 o_almost_full,
  output logic [NUM_CH*(FIFO_DEPTH+1)-1:0]  o_count
`ifdef BANK_FIFO_ERR_STICKY_EN
  ,
  output logic [NUM_CH-1:0]                 o_overflow,
  output logic [NUM_CH-1:0]                 o_underflow
`endif
);

  localparam int CW = FIFO_DEPTH + 1;

  logic [NUM_CH-1:0]     wr_sel, rd_sel;
  logic [DATA_WIDTH-1:0] head   [NUM_CH];
  ch_status_t            status [NUM_CH];

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    // Select codes >= NUM_CH match no channel, so such requests are dropped.
    assign wr_sel[k] = i_wr_en && (i_wr_ch == CH_W'(k));
    assign rd_sel[k] = i_rd_en && (i_rd_ch == CH_W'(k));

    bank_fifo_channel #(
      .DATA_WIDTH (DATA_WIDTH),
      .FIFO_DEPTH (FIFO_DEPTH),
      .AF_LEVEL   (AF_LEVEL)
    ) u_ch (
      .i_clk       (i_clk),
      .i_rst       (i_rst),
      .i_wr        (wr_sel[k]),
      .i_data      (i_data),
      .i_rd        (rd_sel[k]),
      .o_head      (head[k]),
      .o_status    (status[k])
`ifdef BANK_FIFO_ERR_STICKY_EN
      ,
      .o_overflow  (o_overflow[k]),
      .o_underflow (o_underflow[k])
`endif
    );

    assign o_full[k]             = status[k].full;
    assign o_empty[k]            = status[k].empty;
    assign o_almost_full[k]      = status[k].almost_full;
    assign o_count[k*CW +: CW]   = status[k].count[CW-1:0];
  end

  always_comb begin
    o_data = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (i_rd_ch == CH_W'(k)) begin
        o_data = head[k];
      end
    end
  end

endmodule

// File: tb/tb_bank_fifo_array.sv
module tb_bank_fifo_array;

  localparam int DW  = 32;
  localparam int FD  = 4;
  localparam int NCH = 4;
  localparam int AF  = 12;
  localparam int CW  = 2;
  localparam int DEP = 16;

  logic               i_clk = 1'b0;
  logic               i_rst, i_wr_en, i_rd_en;
  logic [CW-1:0]      i_wr_ch, i_rd_ch;
  logic [DW-1:0]      i_data, o_data;
  logic [NCH-1:0]     o_full, o_empty, o_almost_full;
  logic [NCH*(FD+1)-1:0] o_count;
`ifdef BANK_FIFO_ERR_STICKY_EN
  logic [NCH-1:0]     o_overflow, o_underflow;
`endif

  always #5 i_clk = ~i_clk;

  bank_fifo_array #(
    .DATA_WIDTH (DW),
    .FIFO_DEPTH (FD),
    .NUM_CH     (NCH),
    .AF_LEVEL   (AF)
  ) dut (
    .i_clk         (i_clk),
    .i_rst         (i_rst),
    .i_wr_en       (i_wr_en),
    .i_wr_ch       (i_wr_ch),
    .i_data        (i_data),
    .i_rd_en       (i_rd_en),
    .i_rd_ch       (i_rd_ch),
    .o_data        (o_data),
    .o_full        (o_full),
    .o_empty       (o_empty),
    .o_almost_full (o_almost_full),
    .o_count       (o_count)
`ifdef BANK_FIFO_ERR_STICKY_EN
    ,
    .o_overflow    (o_overflow),
    .o_underflow   (o_underflow)
`endif
  );

  // Reference model: one queue per channel plus sticky error bits.
  logic [DW-1:0]  mq [NCH][$];
  logic [NCH-1:0] m_ovf, m_udf;
  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic int ch_count(input int k);
    return int'(o_count[k*(FD+1) +: FD+1]);
  endfunction

  task automatic check_flags();
    logic [NCH-1:0]        ef, ee, ea;
    logic [NCH*(FD+1)-1:0] ec;
    for (int k = 0; k < NCH; k++) begin
      int sz;
      sz = mq[k].size();
      ef[k] = (sz == DEP);
      ee[k] = (sz == 0);
      ea[k] = (sz >= AF);
      ec[k*(FD+1) +: FD+1] = (FD+1)'(sz);
    end
    chk("o_full", 64'(o_full), 64'(ef));
    chk("o_empty", 64'(o_empty), 64'(ee));
    chk("o_almost_full", 64'(o_almost_full), 64'(ea));
    chk("o_count", 64'(o_count), 64'(ec));
`ifdef BANK_FIFO_ERR_STICKY_EN
    chk("o_overflow", 64'(o_overflow), 64'(m_ovf));
    chk("o_underflow", 64'(o_underflow), 64'(m_udf));
`endif
  endtask

  // One clock: drive, check head, advance model across the edge, check flags.
  task automatic cycle(input logic rst, input logic we, input logic [CW-1:0] wc,
                       input logic [DW-1:0] d, input logic re, input logic [CW-1:0] rc);
    bit wr_ok, rd_ok, wr_full, rd_empty;
    i_rst = rst; i_wr_en = we; i_wr_ch = wc; i_data = d; i_rd_en = re; i_rd_ch = rc;
    #1;
    if (mq[rc].size() > 0) chk("o_data", 64'(o_data), 64'(mq[rc][0]));
    wr_full  = (mq[wc].size() == DEP);
    rd_empty = (mq[rc].size() == 0);
    wr_ok = we && (int'(wc) < NCH) && !wr_full;
    rd_ok = re && (int'(rc) < NCH) && !rd_empty;
    @(posedge i_clk);
    if (rst) begin
      for (int k = 0; k < NCH; k++) mq[k].delete();
      m_ovf = '0;
      m_udf = '0;
    end else begin
      if (we && wr_full)  m_ovf[wc] = 1'b1;
      if (re && rd_empty) m_udf[rc] = 1'b1;
      if (rd_ok) void'(mq[rc].pop_front());
      if (wr_ok) mq[wc].push_back(d);
    end
    #1;
    check_flags();
  endtask

  task automatic wr(input int ch, input logic [DW-1:0] d);
    cycle(1'b0, 1'b1, CW'(ch), d, 1'b0, '0);
  endtask

  task automatic rd(input int ch);
    cycle(1'b0, 1'b0, '0, '0, 1'b1, CW'(ch));
  endtask

  initial begin
    m_ovf = '0;
    m_udf = '0;

    // Reset state
    cycle(1'b1, 1'b0, '0, '0, 1'b0, '0);
    cycle(1'b1, 1'b1, 2'd1, 32'h55, 1'b0, '0);
    chk("rst_empty", 64'(o_empty), 64'hF);
    chk("rst_count", 64'(o_count), 64'h0);

    // Fill ch2
    for (int i = 0; i < DEP; i++) begin
      wr(2, 32'hC000 + i);
      if (i == AF - 2) chk("af_below", 64'(o_almost_full[2]), 64'h0);
      if (i == AF - 1) chk("af_at_12", 64'(o_almost_full[2]), 64'h1);
    end
    chk("fill_full2", 64'(o_full[2]), 64'h1);
    chk("fill_other_empty", 64'(o_empty & 4'b1011), 64'hB);

    // Overflow
    wr(2, 32'hDEAD);
    chk("ovf_count2", 64'(ch_count(2)), 64'd16);
`ifdef BANK_FIFO_ERR_STICKY_EN
    chk("ovf_sticky2", 64'(o_overflow[2]), 64'h1);
`endif
    for (int i = 0; i < DEP; i++) rd(2);

    // Interleaved ordering on ch0 / ch3
    for (int i = 0; i < 8; i++) begin
      wr(0, 32'hA0 + i);
      wr(3, 32'hB0 + i);
    end
    for (int i = 0; i < 8; i++) begin
      i_rd_ch = 2'd0; #1;
      chk("ord_ch0", 64'(o_data), 64'(32'hA0 + i));
      rd(0);
    end
    for (int i = 0; i < 8; i++) begin
      i_rd_ch = 2'd3; #1;
      chk("ord_ch3", 64'(o_data), 64'(32'hB0 + i));
      rd(3);
    end

    // Same-channel read+write
    for (int i = 0; i < 5; i++) wr(1, 32'h100 + i);
    cycle(1'b0, 1'b1, 2'd1, 32'h1FF, 1'b1, 2'd1);
    chk("same_ch_cnt5", 64'(ch_count(1)), 64'd5);
    for (int i = 0; i < 5; i++) rd(1);
    cycle(1'b0, 1'b1, 2'd1, 32'h2AA, 1'b1, 2'd1);
    chk("empty_rw_cnt1", 64'(ch_count(1)), 64'd1);
`ifdef BANK_FIFO_ERR_STICKY_EN
    chk("udf_sticky1", 64'(o_underflow[1]), 64'h1);
`endif
    rd(1);

    // Wrap-around on ch0
    for (int i = 0; i < 40; i++) begin
      wr(0, DW'(i));
      chk("wrap_cnt", 64'(ch_count(0) <= 1), 64'h1);
      i_rd_ch = 2'd0; #1;
      chk("wrap_data", 64'(o_data), 64'(i));
      rd(0);
    end

    // Mid-burst reset
    for (int i = 0; i < DEP; i++) begin
      if (i < 7) wr(0, $urandom);
      wr(3, $urandom);
    end
    chk("pre_rst_cnt0", 64'(ch_count(0)), 64'd7);
    chk("pre_rst_cnt3", 64'(ch_count(3)), 64'd16);
    cycle(1'b1, 1'b1, 2'd0, 32'h77, 1'b1, 2'd3);
    chk("mid_rst_empty", 64'(o_empty), 64'hF);
    chk("mid_rst_count", 64'(o_count), 64'h0);

    // Randomized traffic
    for (int i = 0; i < 1500; i++) begin
      int wp;
      wp = ((i / 250) % 2 == 0) ? 70 : 30;
      cycle(($urandom_range(0, 299) == 0),
            ($urandom_range(0, 99) < wp), CW'($urandom_range(0, NCH-1)), $urandom,
            ($urandom_range(0, 99) < (100 - wp)), CW'($urandom_range(0, NCH-1)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
